// File: rtl/fetch_queue.sv
// Show-ahead circular instruction fetch queue with valid/ready on both sides.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fetch_queue #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int AF_MARGIN = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       enq_valid,
   input  logic [DATA_W-1:0]          enq_data,
   output logic                       enq_ready,
   output logic                       deq_valid,
   output logic [DATA_W-1:0]          deq_data,
   input  logic                       deq_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output logic                       almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW:0]       head;
   logic [AW:0]       tail;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              do_enq;
   logic              do_deq;

   assign empty = (head == tail);
   assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
   assign count = CW'(tail - head);
   assign almost_full = (count >= CW'(DEPTH - AF_MARGIN));

   // Ready depends only on registered state, never on deq_ready.
   assign enq_ready = !full;
   assign deq_valid = !empty;
   assign deq_data  = empty ? '0 : mem[head[AW-1:0]];

   assign do_enq = enq_valid && enq_ready && !flush;
   assign do_deq = deq_valid && deq_ready && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head <= '0;
         tail <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (do_enq) tail <= tail + 1'b1;
         if (do_deq) head <= head + 1'b1;
      end
   end

   // Payload storage carries no reset; only pointers are architectural.
   always_ff @(posedge clk) begin
      if (do_enq && rst) mem[tail[AW-1:0]] <= enq_data;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32, entry payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, >= 2.
REQ-003 SHALL have parameter AF_MARGIN, default 1, almost_full threshold offset; range 0..DEPTH-1.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset: asserted when 0, released synchronously to clk by the environment.
REQ-006 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-007 SHALL have port enq_valid  input  1  producer offers enq_data.
REQ-008 SHALL have port enq_data  input  DATA_W  payload to enqueue.
REQ-009 SHALL have port enq_ready  output  1  queue can accept an entry this cycle.
REQ-010 SHALL have port deq_valid  output  1  head entry present on deq_data.
REQ-011 SHALL have port deq_data  output  DATA_W  head entry payload, show-ahead.
REQ-012 SHALL have port deq_ready  input  1  consumer takes the head entry.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-014 SHALL have ports empty, full, almost_full  output  1 each  occupancy flags.

Function
REQ-015 SHALL store entries in a DEPTH-entry circular buffer with head and tail pointers of $clog2(DEPTH) bits plus one wrap bit each.
REQ-016 SHALL perform an enqueue on a rising edge exactly when enq_valid && enq_ready && !flush; enq_data written at tail, tail advances by 1.
REQ-017 SHALL perform a dequeue on a rising edge exactly when deq_valid && deq_ready && !flush; head advances by 1.
REQ-018 SHALL drive enq_ready = !full; enq_ready independent of deq_ready (no combinational ready path).
REQ-019 SHALL drive deq_valid = !empty and deq_data = buffer[head] combinationally from registered state (zero-cycle read latency).
REQ-020 SHALL drive deq_data to all-zero when empty.
REQ-021 SHALL, on simultaneous enqueue and dequeue with 0 < count < DEPTH, leave count unchanged and advance both pointers.
REQ-022 SHALL, when empty, ignore deq_ready; an enqueue in that cycle becomes visible on deq_valid/deq_data the following cycle (no bypass).
REQ-023 SHALL, when full, refuse enqueue even if a dequeue occurs the same cycle; count becomes DEPTH-1.
REQ-024 SHALL wrap both pointers from DEPTH-1 to 0, toggling the wrap bit; full = (index bits equal, wrap bits differ); empty = (pointers fully equal).
REQ-025 SHALL derive count = tail - head in wrap-extended arithmetic; count always in 0..DEPTH.
REQ-026 SHALL drive almost_full = (count >= DEPTH - AF_MARGIN); with AF_MARGIN = 0, almost_full equals full.
REQ-027 SHALL, on flush, set head = tail = 0 at the next rising edge; flush dominates same-cycle enqueue and dequeue.
REQ-028 SHALL leave buffer contents unspecified after flush or reset; only pointer state is architecturally visible.
REQ-029 SHALL keep all outputs stable between rising edges except through REQ-019 combinational paths.

Reset
REQ-030 SHALL, while rst = 0, asynchronously force head = 0, tail = 0, regardless of clk.
REQ-031 SHALL present during and after reset: empty = 1, full = 0, almost_full = 0 (or 1 if DEPTH - AF_MARGIN = 0, not allowed), count = 0, enq_ready = 1, deq_valid = 0, deq_data = 0.
REQ-032 SHALL, on reset asserted mid-operation, discard all entries; no enqueue or dequeue completes at an edge where rst = 0.

Verification (DEPTH=8, DATA_W=32, AF_MARGIN=1)
REQ-033 SHALL cover: reset, then enqueue 0xAAAAAAAA, 0xBABEBABE with deq_ready=0 -> count=2, deq_data=0xAAAAAAAA, empty=0.
REQ-034 SHALL cover: enqueue 8 entries 0x11111111..0x88888888 -> almost_full=1 after 7th, full=1 and enq_ready=0 after 8th; 9th offer 0x99999999 not stored.
REQ-035 SHALL cover: full queue, enq_valid=1 and deq_ready=1 for one cycle -> dequeues 0x11111111, no enqueue, count=7, full=0.
REQ-036 SHALL cover: 20 cycles simultaneous enq/deq at count=3 -> count stays 3, pointers wrap, output order matches input order exactly.
REQ-037 SHALL cover: count=5, flush=1 with enq_valid=1 same cycle -> next cycle count=0, empty=1, deq_valid=0.
REQ-038 SHALL cover: count=4, rst driven 0 between clock edges -> empty=1, count=0 immediately, before next rising edge.
